pll_ctrl: RTL
=============

PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 64: cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed for lock per attempt.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before ready.
REQ-004 SHALL have port clkin, input, 1 bit: free-running controller clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port pll_lock, input, 1 bit: raw PLL lock, asynchronous to clkin.
REQ-007 SHALL have port pll_reset, output, 1 bit: PLL reset.
REQ-008 SHALL have port icpsel, output, 6 bits: dynamic charge-pump select.
REQ-009 SHALL have port lpfres, output, 3 bits: dynamic loop-filter resistor select.
REQ-010 SHALL have port lpfcap, output, 2 bits: dynamic loop-filter capacitor select.
REQ-011 SHALL have port retune_req, input, 1 bit: host restart request.
REQ-012 SHALL have port retune_ack, output, 1 bit: one-cycle acceptance pulse.
REQ-013 SHALL have port clk_ready, output, 1 bit: PLL locked and stable.
REQ-014 SHALL have port fail, output, 1 bit: all settings exhausted.
REQ-015 SHALL have port attempt, output, 2 bits: current settings-table index.
REQ-016 SHALL have port relock_count, output, 8 bits: saturating count of lock losses seen after ready.

Function
REQ-017 SHALL synchronise pll_lock through 2 flops (lock_s); all decisions use lock_s.
REQ-018 SHALL drive icpsel/lpfres/lpfcap from a fixed 4-entry table indexed by attempt:
- 0 = 24/3'b011/2'b00
- 1 = 16/3'b010/2'b00
- 2 = 32/3'b100/2'b01
- 3 = 8/3'b001/2'b00
REQ-019 SHALL change attempt, and therefore the table outputs, only while pll_reset=1.
REQ-020 SHALL implement states RESET_HOLD, WAIT_LOCK, STABLE_CHECK, LOCKED, FAIL.
REQ-021 RESET_HOLD: pll_reset=1; after RESET_CYCLES cycles, go to WAIT_LOCK and drive pll_reset=0.
REQ-022 WAIT_LOCK, lock_s=1: go to STABLE_CHECK.
REQ-023 WAIT_LOCK, LOCK_TIMEOUT cycles elapse without lock: if attempt<3, attempt+1 and go to RESET_HOLD; if attempt=3, go to FAIL.
REQ-024 STABLE_CHECK, lock_s high for STABLE_CYCLES consecutive cycles: go to LOCKED, clk_ready=1.
REQ-025 STABLE_CHECK, any lock_s low: go to RESET_HOLD, attempt unchanged, relock_count unchanged.
REQ-026 LOCKED, lock_s low: clk_ready=0 next cycle, relock_count +1 saturating at 255, go to RESET_HOLD, attempt unchanged.
REQ-027 FAIL: pll_reset=1, fail=1, clk_ready=0; FAIL is left only by retune or reset.
REQ-028 retune_req SHALL be accepted on its rising edge (high now, low previous cycle) in any state.
REQ-029 On acceptance: retune_ack=1 for exactly the next cycle; attempt=0; fail=0; clk_ready=0; all timers cleared; go to RESET_HOLD.
REQ-030 A held retune_req SHALL NOT re-trigger.
REQ-031 Retune SHALL take priority over timeout or lock-loss in the same cycle; relock_count is not incremented in that cycle.
REQ-032 Every timer SHALL restart from 0 on each state entry.
REQ-033 Timer widths SHALL hold the parameter value without wrap.
REQ-034 clk_ready SHALL be high only in LOCKED.

Reset
REQ-035 On reset=1 at a clock edge, the block SHALL apply:
- state RESET_HOLD, pll_reset=1, attempt=0, table entry 0 on outputs
- clk_ready=0, fail=0, retune_ack=0, relock_count=0
- timers=0, synchroniser and edge-detect flops=0
REQ-036 Reset asserted mid-sequence SHALL override all other events in that cycle.

Verification (RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8)
REQ-037 Release reset, raise pll_lock at cycle 10 -> pll_reset falls after 4 cycles; clk_ready rises after 2-flop sync plus 8 stable cycles; attempt=0.
REQ-038 pll_lock held 0 -> attempt steps 0,1,2,3 with table values changing only while pll_reset=1; then fail=1, pll_reset=1.
REQ-039 In LOCKED, drop pll_lock for 1 cycle -> clk_ready=0, relock_count=1, RESET_HOLD re-entered, attempt unchanged; relock 300 times -> relock_count=255.
REQ-040 Glitch pll_lock low during STABLE_CHECK -> return to RESET_HOLD; relock_count stays 0.
REQ-041 In FAIL, pulse retune_req, then hold it 20 cycles -> a single retune_ack; attempt=0, fail=0, sequence restarts.
REQ-042 retune_req rising in the same cycle as a lock loss in LOCKED -> retune handled, attempt=0, relock_count unchanged.

Source files
------------

// File: rtl/pll_ctrl.sv
// pll_ctrl: bring-up and supervision controller for a PLL with dynamic
// loop settings.
//
// The controller holds the PLL in reset, releases it, waits for lock and
// then requires lock to stay up for a run of consecutive cycles before
// reporting clk_ready. If lock never arrives, the next charge-pump and
// loop-filter setting from a small table is tried. When every setting has
// failed, the controller parks in FAIL until the host asks for a retune.
//
// Ports
//   clkin        : free-running controller clock, rising-edge logic only
//   reset        : synchronous, active-high
//   pll_lock     : raw PLL lock, asynchronous to clkin
//   pll_reset    : PLL reset
//   icpsel       : charge-pump select for the current setting
//   lpfres       : loop-filter resistor select for the current setting
//   lpfcap       : loop-filter capacitor select for the current setting
//   retune_req   : host restart request, acted on at its rising edge
//   retune_ack   : one-cycle pulse when a retune request is accepted
//   clk_ready    : PLL locked and stable
//   fail         : every setting in the table has been tried without lock
//   attempt      : index of the setting currently applied
//   relock_count : saturating count of lock losses seen after clk_ready
module pll_ctrl #(
    parameter int RESET_CYCLES  = 64,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic [1:0] lpfcap,
    input  logic       retune_req,
    output logic       retune_ack,
    output logic       clk_ready,
    output logic       fail,
    output logic [1:0] attempt,
    output logic [7:0] relock_count
);

    // One shared timer serves every state, so it is sized for the longest
    // interval and never wraps before reaching its terminal count.
    localparam int MAX_RS     = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYCLES = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABLE_CHECK,
        LOCKED,
        FAIL
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          lock_meta;
    logic          lock_s;
    logic          retune_prev;
    logic          attempt_pending;
    logic [1:0]    attempt_next;
    logic          retune_rise;

    assign retune_rise = retune_req & ~retune_prev;

    // Loop settings are a pure function of the registered attempt index, so
    // they can only move when attempt moves.
    always_comb begin
        icpsel = 6'd24;
        lpfres = 3'b011;
        lpfcap = 2'b00;
        case (attempt)
            2'd0: begin icpsel = 6'd24; lpfres = 3'b011; lpfcap = 2'b00; end
            2'd1: begin icpsel = 6'd16; lpfres = 3'b010; lpfcap = 2'b00; end
            2'd2: begin icpsel = 6'd32; lpfres = 3'b100; lpfcap = 2'b01; end
            default: begin icpsel = 6'd8; lpfres = 3'b001; lpfcap = 2'b00; end
        endcase
    end

    // Synchroniser, retune edge detector and the sequencing FSM.
    // A new attempt index is never applied in the same cycle that pll_reset
    // rises: it is parked in attempt_next and loaded on the first cycle of
    // RESET_HOLD, when the PLL is already observed in reset. The hold does
    // not end while a load is pending, which only matters if RESET_CYCLES=1.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state           <= RESET_HOLD;
            timer           <= '0;
            lock_meta       <= 1'b0;
            lock_s          <= 1'b0;
            retune_prev     <= 1'b0;
            attempt_pending <= 1'b0;
            attempt_next    <= 2'd0;
            attempt         <= 2'd0;
            pll_reset       <= 1'b1;
            retune_ack      <= 1'b0;
            clk_ready       <= 1'b0;
            fail            <= 1'b0;
            relock_count    <= 8'd0;
        end else begin
            lock_meta   <= pll_lock;
            lock_s      <= lock_meta;
            retune_prev <= retune_req;
            retune_ack  <= 1'b0;

            if (retune_rise) begin
                // Retune wins over any timeout or lock loss this cycle.
                retune_ack <= 1'b1;
                fail       <= 1'b0;
                clk_ready  <= 1'b0;
                timer      <= '0;
                state      <= RESET_HOLD;
                pll_reset  <= 1'b1;
                if (pll_reset) begin
                    attempt         <= 2'd0;
                    attempt_pending <= 1'b0;
                end else begin
                    attempt_next    <= 2'd0;
                    attempt_pending <= 1'b1;
                end
            end else begin
                case (state)
                    RESET_HOLD: begin
                        if (attempt_pending) begin
                            attempt         <= attempt_next;
                            attempt_pending <= 1'b0;
                        end
                        if (timer >= RESET_LAST && !attempt_pending) begin
                            state     <= WAIT_LOCK;
                            pll_reset <= 1'b0;
                            timer     <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE_CHECK;
                            timer <= '0;
                        end else if (timer == TIMEOUT_LAST) begin
                            timer     <= '0;
                            pll_reset <= 1'b1;
                            if (attempt != 2'd3) begin
                                state           <= RESET_HOLD;
                                attempt_next    <= attempt + 2'd1;
                                attempt_pending <= 1'b1;
                            end else begin
                                state <= FAIL;
                                fail  <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    STABLE_CHECK: begin
                        if (!lock_s) begin
                            state     <= RESET_HOLD;
                            pll_reset <= 1'b1;
                            timer     <= '0;
                        end else if (timer == STABLE_LAST) begin
                            state     <= LOCKED;
                            clk_ready <= 1'b1;
                            timer     <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!lock_s) begin
                            state     <= RESET_HOLD;
                            pll_reset <= 1'b1;
                            clk_ready <= 1'b0;
                            timer     <= '0;
                            if (relock_count != 8'hFF) begin
                                relock_count <= relock_count + 8'd1;
                            end
                        end
                    end
                    FAIL: begin
                        pll_reset <= 1'b1;
                        fail      <= 1'b1;
                        clk_ready <= 1'b0;
                        timer     <= '0;
                    end
                    default: begin
                        state     <= RESET_HOLD;
                        pll_reset <= 1'b1;
                        timer     <= '0;
                    end
                endcase
            end
        end
    end

endmodule
